hazard_fwd_ctrl: RTL

//  Issue-stage hazard and forwarding controller for the pipelined datapath. Tracks in-flight register writes in

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/hazard_fwd_ctrl_if.sv | 40 ++++
 rtl/fwd_match.sv | 35 +++
 rtl/hazard_fwd_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding-mux encodings, the PC register index and
// the pipeline tracking slot layouts used by the hazard/forwarding controller.
package cpu_pkg;

  localparam int unsigned RegAw  = 4;
  localparam int unsigned PC_REG = 15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_ALU = 2'b01,
    FWD_LDR = 2'b10,
    FWD_PC  = 2'b11
  } fwd_sel_e;

  // ALU-result destinations retire at the end of EX, so only EX carries them.
  typedef struct packed {
    logic             v;
    logic             wa_en;
    logic [RegAw-1:0] wa_addr;
    logic             wl_en;
    logic [RegAw-1:0] wl_addr;
  } ex_slot_t;

  typedef struct packed {
    logic             v;
    logic             wl_en;
    logic [RegAw-1:0] wl_addr;
  } mem_slot_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side request and datapath-side control bundle of the hazard/forwarding
// controller; master is the decode/datapath side, slave is the controller.
interface hazard_fwd_ctrl_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 16
);
  logic          dec_valid;
  logic [AW-1:0] dec_a_addr;
  logic          dec_a_use;
  logic [AW-1:0] dec_b_addr;
  logic          dec_b_use;
  logic [AW-1:0] dec_s_addr;
  logic          dec_s_use;
  logic          dec_wa_en;
  logic [AW-1:0] dec_wa_addr;
  logic          dec_wl_en;
  logic [AW-1:0] dec_wl_addr;
  logic          flush;

  logic [1:0]       sel_A_in;
  logic [1:0]       sel_B_in;
  logic [1:0]       sel_shift_in;
  logic             en_A;
  logic             en_B;
  logic             en_S;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_valid, dec_a_addr, dec_a_use, dec_b_addr, dec_b_use, dec_s_addr, dec_s_use,
           dec_wa_en, dec_wa_addr, dec_wl_en, dec_wl_addr, flush,
    input  sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_a_addr, dec_a_use, dec_b_addr, dec_b_use, dec_s_addr, dec_s_use,
           dec_wa_en, dec_wa_addr, dec_wl_en, dec_wl_addr, flush,
    output sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_match.sv
// Per-source forwarding resolver: picks the operand mux select for one source
// register and flags a load-use hazard that needs a bubble.
module fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned AW    = RegAw,
  parameter int unsigned PcReg = PC_REG
) (
  input  logic [AW-1:0] addr_i,
  input  logic          use_i,   // already qualified by valid, flush and reset
  input  logic          is_a_i,
  input  ex_slot_t      ex_slot_i,
  input  mem_slot_t     mem_slot_i,
  output fwd_sel_e      sel_o,
  output logic          stall_req_o
);

  always_comb begin
    sel_o       = FWD_RF;
    stall_req_o = 1'b0;
    if (use_i) begin
      if (addr_i == AW'(PcReg)) begin
        sel_o = is_a_i ? FWD_PC : FWD_RF;
      end else if (ex_slot_i.v && ex_slot_i.wl_en && ex_slot_i.wl_addr == addr_i) begin
        // Load data not available until end of MEM: bubble, select is don't-care.
        stall_req_o = 1'b1;
      end else if (ex_slot_i.v && ex_slot_i.wa_en && ex_slot_i.wa_addr == addr_i) begin
        sel_o = FWD_ALU;
      end else if (mem_slot_i.v && mem_slot_i.wl_en && mem_slot_i.wl_addr == addr_i) begin
        sel_o = FWD_LDR;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Issue-stage hazard and forwarding controller: tracks in-flight writes in EX/MEM,
// drives operand forwarding selects and enables, and inserts load-use bubbles.
module hazard_fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned AW     = RegAw,
  parameter int unsigned PC_REG = 15,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  ex_slot_t         ex_slot_q, ex_slot_d;
  mem_slot_t        mem_slot_q, mem_slot_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  fwd_sel_e sel_a, sel_b, sel_s;
  logic     req_a, req_b, req_s;
  logic     qual, stall, issue;

  assign qual = rst_n & bus.dec_valid & ~bus.flush;

  fwd_match #(.AW(AW), .PcReg(PC_REG)) u_match_a (
    .addr_i      (bus.dec_a_addr),
    .use_i       (qual & bus.dec_a_use),
    .is_a_i      (1'b1),
    .ex_slot_i   (ex_slot_q),
    .mem_slot_i  (mem_slot_q),
    .sel_o       (sel_a),
    .stall_req_o (req_a)
  );

  fwd_match #(.AW(AW), .PcReg(PC_REG)) u_match_b (
    .addr_i      (bus.dec_b_addr),
    .use_i       (qual & bus.dec_b_use),
    .is_a_i      (1'b0),
    .ex_slot_i   (ex_slot_q),
    .mem_slot_i  (mem_slot_q),
    .sel_o       (sel_b),
    .stall_req_o (req_b)
  );

  fwd_match #(.AW(AW), .PcReg(PC_REG)) u_match_s (
    .addr_i      (bus.dec_s_addr),
    .use_i       (qual & bus.dec_s_use),
    .is_a_i      (1'b0),
    .ex_slot_i   (ex_slot_q),
    .mem_slot_i  (mem_slot_q),
    .sel_o       (sel_s),
    .stall_req_o (req_s)
  );

  assign stall = req_a | req_b | req_s;
  assign issue = qual & ~stall;

  assign bus.sel_A_in     = sel_a;
  assign bus.sel_B_in     = sel_b;
  assign bus.sel_shift_in = sel_s;
  assign bus.en_A         = issue;
  assign bus.en_B         = issue;
  assign bus.en_S         = issue;
  assign bus.stall        = stall;
  assign bus.stall_cnt    = stall_cnt_q;

  always_comb begin
    mem_slot_d = '{v: ex_slot_q.v, wl_en: ex_slot_q.wl_en, wl_addr: ex_slot_q.wl_addr};
    ex_slot_d  = '0;
    if (issue) begin
      ex_slot_d = '{v:       1'b1,
                    wa_en:   bus.dec_wa_en,
                    wa_addr: bus.dec_wa_addr,
                    wl_en:   bus.dec_wl_en,
                    wl_addr: bus.dec_wl_addr};
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_slot_q   <= '0;
      mem_slot_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_slot_q   <= ex_slot_d;
      mem_slot_q  <= mem_slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
